// File: rtl/conv3x3_window_ctrl.sv
// -----------------------------------------------------------------------------
// conv3x3_window_ctrl
//
// Sequencer for a 3x3 convolution front end built from two cascaded line
// buffers and a 3x3 window register bank. The pixel data path itself lives
// outside this block; this controller only decides when the chain shifts,
// tracks the raster position of the incoming pixel and announces each valid
// (unpadded) 3x3 window together with its top-left output coordinate.
//
// Handshakes (both follow strict valid/ready rules): a transfer happens on a
// rising clock edge where valid and ready are both high. A producer holding
// valid keeps its payload stable until that transfer; ready may depend
// combinationally on valid-side state, valid never depends on ready.
//   - pixel side : i_px_valid / o_px_ready, transfer strobe is o_lb_shift
//   - window side: o_win_valid / i_win_ready, payload o_win_col/row/last
//
// Ports:
//   i_clk, i_reset   clock, synchronous active-high reset
//   i_start          frame start pulse, only honoured while idle
//   o_busy           high while a frame is being streamed or drained
//   i_px_valid       upstream pixel valid
//   o_px_ready       controller can accept a pixel this cycle
//   o_lb_shift       shift/write strobe to line buffers and window registers
//   o_win_valid      3x3 window at the datapath output is valid
//   i_win_ready      downstream consumes the window
//   o_win_col/row    output coordinate of the window (top-left based)
//   o_win_last       marks the final window of the frame
//   o_frame_done     one-cycle pulse when the frame has fully drained
//   o_dbg_state      current FSM state, for checkers and debug
// -----------------------------------------------------------------------------
module conv3x3_window_ctrl #(
   parameter int IMG_W = 8,
   parameter int IMG_H = 8,
   parameter int CW    = $clog2(IMG_W),
   parameter int RW    = $clog2(IMG_H)
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_start,
   output logic          o_busy,
   input  logic          i_px_valid,
   output logic          o_px_ready,
   output logic          o_lb_shift,
   output logic          o_win_valid,
   input  logic          i_win_ready,
   output logic [CW-1:0] o_win_col,
   output logic [RW-1:0] o_win_row,
   output logic          o_win_last,
   output logic          o_frame_done,
   output logic [1:0]    o_dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_RUN       = 2'd1,
      S_WAIT_LAST = 2'd2,
      S_DONE      = 2'd3
   } state_t;

   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
   localparam logic [CW-1:0] COL_TWO  = CW'(2);
   localparam logic [RW-1:0] ROW_TWO  = RW'(2);

   state_t        r_state;
   logic [CW-1:0] r_col;
   logic [RW-1:0] r_row;
   logic          r_win_valid;
   logic [CW-1:0] r_win_col;
   logic [RW-1:0] r_win_row;
   logic          r_win_last;
   logic          r_frame_done;
   logic          r_busy;

   logic          w_px_ready;
   logic          w_accept;
   logic          w_handshake;
   logic          w_qualify;
   logic          w_last_px;

   // A pixel can only enter the chain when the window stage is empty or is
   // being emptied this very cycle; otherwise the window registers would be
   // overwritten before downstream has taken the pending window.
   assign w_px_ready  = (r_state == S_RUN) && (!r_win_valid || i_win_ready);
   assign w_accept    = i_px_valid && w_px_ready;
   assign w_handshake = r_win_valid && i_win_ready;

   // The pixel at (col,row) completes the window whose top-left corner is
   // (col-2,row-2); the first two columns and rows never complete a window.
   assign w_qualify   = (r_col >= COL_TWO) && (r_row >= ROW_TWO);
   assign w_last_px   = (r_col == COL_LAST) && (r_row == ROW_LAST);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= S_IDLE;
         r_col        <= '0;
         r_row        <= '0;
         r_win_valid  <= 1'b0;
         r_win_col    <= '0;
         r_win_row    <= '0;
         r_win_last   <= 1'b0;
         r_frame_done <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_state     <= S_RUN;
                  r_col       <= '0;
                  r_row       <= '0;
                  r_win_valid <= 1'b0;
                  r_win_last  <= 1'b0;
                  r_busy      <= 1'b1;
               end
            end

            S_RUN: begin
               if (w_accept) begin
                  if (r_col == COL_LAST) begin
                     r_col <= '0;
                     // Park the row counter at 0 after the final pixel so a
                     // non power-of-two height never leaves it out of range.
                     r_row <= w_last_px ? '0 : r_row + RW'(1);
                  end else begin
                     r_col <= r_col + CW'(1);
                  end
                  if (w_last_px) begin
                     r_state <= S_WAIT_LAST;
                  end
               end

               // A qualifying accept wins over a handshake: the old window is
               // consumed and the new one loads in the same edge.
               if (w_accept && w_qualify) begin
                  r_win_valid <= 1'b1;
                  r_win_col   <= r_col - COL_TWO;
                  r_win_row   <= r_row - ROW_TWO;
                  r_win_last  <= w_last_px;
               end else if (w_handshake) begin
                  r_win_valid <= 1'b0;
                  r_win_last  <= 1'b0;
               end
            end

            S_WAIT_LAST: begin
               // Only the last window can be pending here; its handshake
               // closes the frame.
               if (w_handshake) begin
                  r_win_valid  <= 1'b0;
                  r_win_last   <= 1'b0;
                  r_state      <= S_DONE;
                  r_busy       <= 1'b0;
                  r_frame_done <= 1'b1;
               end
            end

            S_DONE: begin
               r_state <= S_IDLE;
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_px_ready   = w_px_ready;
   assign o_lb_shift   = w_accept;
   assign o_win_valid  = r_win_valid;
   assign o_win_col    = r_win_col;
   assign o_win_row    = r_win_row;
   assign o_win_last   = r_win_last;
   assign o_frame_done = r_frame_done;
   assign o_busy       = r_busy;
   assign o_dbg_state  = r_state;

endmodule

// File: doc/conv3x3_window_ctrl.md
Name: conv3x3_window_ctrl

Overview:
- Sequencer for the 3x3 convolution front end: two cascaded line buffers plus 3x3 window registers.
- Gates the raster pixel stream into the line-buffer chain via a single shift strobe and tracks the column and row position.
- Emits one window-valid per valid 3x3 position (no padding) with its coordinates, and applies downstream backpressure.
- Frame-oriented: armed by a start pulse, signals completion after the last window is consumed.

Parameters:
- IMG_W, 8, frame width in pixels (>=3).
- IMG_H, 8, frame height in rows (>=3).
- CW, $clog2(IMG_W), column counter and coordinate width (derived).
- RW, $clog2(IMG_H), row counter and coordinate width (derived).

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous reset, active-high.
- i_start  in  1  frame start pulse; honoured only in IDLE.
- o_busy  out  1  high in RUN and WAIT_LAST.
- i_px_valid  in  1  upstream pixel valid (data goes straight to the line buffers).
- o_px_ready  out  1  controller accepts a pixel this cycle.
- o_lb_shift  out  1  combinational = i_px_valid && o_px_ready; write/shift strobe to line buffers and window registers.
- o_win_valid  out  1  3x3 window at the datapath output is valid.
- i_win_ready  in  1  downstream consumes the window.
- o_win_col  out  CW  output x coordinate (0..IMG_W-3).
- o_win_row  out  RW  output y coordinate (0..IMG_H-3).
- o_win_last  out  1  qualifies the final window of the frame.
- o_frame_done  out  1  one-cycle pulse at frame completion.

Behaviour:
- States are IDLE, RUN, WAIT_LAST and DONE.
- Reset:
  - State goes to IDLE and col/row counters to 0.
  - o_win_valid, o_win_col, o_win_row, o_win_last, o_frame_done and o_busy are 0.
  - o_px_ready is 0, hence o_lb_shift is 0.
  - Reset in any state aborts the frame; a pending window is dropped.
- IDLE:
  - o_px_ready is 0.
  - i_start moves to RUN; counters are cleared to 0.
- RUN:
  - o_px_ready = !o_win_valid || i_win_ready (single-stage skid-free pipeline).
  - Accept = i_px_valid && o_px_ready. On accept, the pixel is at position (col, row).
  - Column advance: col increments; at col == IMG_W-1, col wraps to 0 and row increments.
  - Window generation: an accept with col >= 2 and row >= 2 registers o_win_valid=1 next cycle, with o_win_col = col-2 and o_win_row = row-2.
  - Accepts at col < 2 or row < 2 produce no window.
- Window output:
  - o_win_valid and its coordinates/last are held stable until i_win_ready.
  - Handshake = o_win_valid && i_win_ready.
  - Handshake without a new qualifying accept in the same cycle clears o_win_valid next cycle.
  - Simultaneous handshake and qualifying accept reloads o_win_valid=1 with the new coordinates.
- Latency: exactly 1 cycle from the qualifying accept edge to o_win_valid.
- Frame end:
  - The accept at (IMG_W-1, IMG_H-1) produces a window with o_win_last=1 and moves to WAIT_LAST.
  - WAIT_LAST: o_px_ready=0; on the last-window handshake, go to DONE.
  - DONE: o_frame_done=1 for exactly one cycle, then IDLE.
- Window count per frame is exactly (IMG_W-2)*(IMG_H-2); none are lost or duplicated under any backpressure.
- i_start is ignored outside IDLE. i_px_valid is ignored in IDLE, WAIT_LAST and DONE.
- o_busy is a registered decode of state (RUN or WAIT_LAST).

Test Plan:
- Reset and idle: assert i_reset for 2 cycles, hold i_px_valid=1 with no start for 5 cycles -> all outputs 0; o_px_ready and o_lb_shift stay 0.
- Streaming frame: 8x8, i_start, continuous i_px_valid, i_win_ready=1 -> 64 accepts in 64 consecutive cycles.
  - First o_win_valid appears the cycle after the 19th accept, at (0,0).
  - 36 windows total in raster order.
  - o_win_last only on (5,5).
  - o_frame_done pulses 1 cycle after the last handshake; o_busy drops the same cycle.
- Row wrap: check the accepts at col 0 and col 1 of rows 2..7 -> no window; col wraps 7->0 with row+1; o_win_col sequence per row is 0..5.
- Backpressure:
  - Drop i_win_ready for 4 cycles while a window is pending -> o_px_ready=0, no o_lb_shift, coordinates held.
  - Release -> streaming resumes; total is still 36 unique windows.
  - With random i_px_valid/i_win_ready over 3 frames -> 108 windows, coordinates match a model.
- Reset mid-frame: reset after 30 accepts -> next cycle is IDLE, o_win_valid=0, o_busy=0; a fresh i_start frame yields a correct 36-window sequence from (0,0).
- Start handling:
  - i_start during RUN and during DONE -> ignored, no counter disturbance.
  - i_start the cycle after o_frame_done -> second frame starts cleanly.
